// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// fir_pkg : width helpers and shared round/limit arithmetic for MSO filters.
// Rev 1.0
// ============================================================================
package fir_pkg;

    localparam int ARITH_W = 64;

    typedef logic signed [ARITH_W-1:0] arith_t;

    typedef struct packed {
        logic   ovf;
        arith_t value;
    } limit_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int prod_width(input int dw, input int cw);
        return dw + cw;
    endfunction

    function automatic int acc_width(input int dw, input int cw, input int taps);
        return dw + cw + clog2(taps);
    endfunction

    // Round-half-up: bias by half an output LSB, then arithmetic shift.
    function automatic arith_t round_shift(input arith_t acc, input int shift);
        if (shift > 0) begin
            return (acc + (arith_t'(1) <<< (shift - 1))) >>> shift;
        end
        return acc;
    endfunction

    function automatic limit_t saturate(input arith_t y, input int width);
        limit_t res;
        arith_t max_v;
        arith_t min_v;
        max_v     = (arith_t'(1) <<< (width - 1)) - arith_t'(1);
        min_v     = -max_v - arith_t'(1);
        res.ovf   = 1'b0;
        res.value = y;
        if (y > max_v) begin
            res.ovf   = 1'b1;
            res.value = max_v;
        end else if (y < min_v) begin
            res.ovf   = 1'b1;
            res.value = min_v;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_delay_bank.sv
`default_nettype none
// ============================================================================
// fir_delay_bank : NUM_CH x NUM_TAPS sample history, per-channel shift, global flush.
// Rev 1.0
// ============================================================================
module fir_delay_bank
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_TAPS   = 4,
    parameter int NUM_CH     = 1
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         shift_en,
    input  logic [((NUM_CH > 1) ? clog2(NUM_CH) : 1)-1:0] wr_ch,
    input  logic [DATA_WIDTH-1:0]                        data_in,
    input  logic                                         flush,
    input  logic [((NUM_CH > 1) ? clog2(NUM_CH) : 1)-1:0] rd_ch,
    output logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]          rd_taps
);
    localparam int CH_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;

    logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] r_line [NUM_CH];

    // A flush coinciding with a shift leaves only the new sample in that line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_line[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (shift_en && (wr_ch == CH_W'(c))) begin
                    r_line[c][0] <= data_in;
                    for (int t = 1; t < NUM_TAPS; t++) begin
                        r_line[c][t] <= flush ? '0 : r_line[c][t-1];
                    end
                end else if (flush) begin
                    r_line[c] <= '0;
                end
            end
        end
    end

    always_comb begin
        rd_taps = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch == CH_W'(c)) begin
                rd_taps = r_line[c];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_pipe.sv
`default_nettype none
// ============================================================================
// fir_pipe : 3-stage multi-channel FIR with double-buffered coefficients.
// Build option FIR_SAT_EN: clamp out-of-range results and flag ovf.
// Rev 1.0
// ============================================================================
module fir_pipe
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 8,
    parameter int NUM_TAPS    = 4,
    parameter int NUM_CH      = 1,
    parameter int OUT_SHIFT   = 0
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    input  logic                                          in_first,
    input  logic signed [DATA_WIDTH-1:0]                  data_in,
    input  logic                                          flush,
    input  logic                                          coeff_we,
    input  logic [clog2(NUM_TAPS)-1:0]                    coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0]                 coeff_data,
    input  logic                                          coeff_commit,
    output logic                                          out_valid,
    output logic [((NUM_CH > 1) ? clog2(NUM_CH) : 1)-1:0] out_ch,
    output logic signed [DATA_WIDTH-1:0]                  data_out,
    output logic                                          ovf
);
    localparam int PROD_W = prod_width(DATA_WIDTH, COEFF_WIDTH);
    localparam int ACC_W  = acc_width(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS);
    localparam int CH_W   = (NUM_CH > 1) ? clog2(NUM_CH) : 1;

    logic [NUM_TAPS-1:0][COEFF_WIDTH-1:0] r_shadow, r_active, r_s1_coef;
    logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]  w_taps;
    logic [CH_W-1:0]                      r_ch_cnt, w_ch_sel, w_ch_next, r_s1_ch, r_s2_ch;
    logic                                 r_s1_valid, r_s2_valid;
    logic signed [PROD_W-1:0]             r_prod [NUM_TAPS];
    logic signed [ACC_W-1:0]              w_acc;
    arith_t                               w_y;
    logic [DATA_WIDTH-1:0]                w_out;
    logic                                 w_ovf;
    logic                                 w_unused;

    always_comb begin
        w_ch_sel  = in_first ? '0 : r_ch_cnt;
        w_ch_next = (w_ch_sel == CH_W'(NUM_CH - 1)) ? '0 : w_ch_sel + CH_W'(1);
    end

    // A commit copies the pre-edge shadow, so a same-cycle write stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            if (coeff_we)     r_shadow[coeff_addr] <= coeff_data;
            if (coeff_commit) r_active <= r_shadow;
        end
    end

    // S1 snapshots the active bank so a sample on a commit edge keeps the old set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch_cnt   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_ch    <= '0;
            r_s1_coef  <= '0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_ch_cnt  <= w_ch_next;
                r_s1_ch   <= w_ch_sel;
                r_s1_coef <= r_active;
            end
        end
    end

    fir_delay_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_TAPS   (NUM_TAPS),
        .NUM_CH     (NUM_CH)
    ) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (in_valid),
        .wr_ch    (w_ch_sel),
        .data_in  (data_in),
        .flush    (flush),
        .rd_ch    (r_s1_ch),
        .rd_taps  (w_taps)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_ch    <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_ch <= r_s1_ch;
                for (int i = 0; i < NUM_TAPS; i++) begin
                    r_prod[i] <= PROD_W'($signed(w_taps[i])) * PROD_W'($signed(r_s1_coef[i]));
                end
            end
        end
    end

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            w_acc = w_acc + ACC_W'(r_prod[i]);
        end
        w_y = round_shift(arith_t'(w_acc), OUT_SHIFT);
    end

`ifdef FIR_SAT_EN
    limit_t w_lim;
    always_comb begin
        w_lim    = saturate(w_y, DATA_WIDTH);
        w_out    = w_lim.value[DATA_WIDTH-1:0];
        w_ovf    = w_lim.ovf;
        w_unused = ^w_lim.value[ARITH_W-1:DATA_WIDTH];
    end
`else
    always_comb begin
        w_out    = w_y[DATA_WIDTH-1:0];
        w_ovf    = 1'b0;
        w_unused = ^w_y[ARITH_W-1:DATA_WIDTH];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            data_out  <= '0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                out_ch   <= r_s2_ch;
                data_out <= w_out;
                ovf      <= w_ovf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_pipe.sv
`default_nettype none
// ============================================================================
// tb_fir_pipe : directed checks of fir_pipe (default, 2-channel, OUT_SHIFT=2).
// Rev 1.0
// ============================================================================
module tb_fir_pipe;

`ifdef FIR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk          = 1'b0;
    logic              rst_n        = 1'b0;
    logic              in_valid     = 1'b0;
    logic              in_first     = 1'b0;
    logic signed [15:0] data_in     = '0;
    logic              flush        = 1'b0;
    logic              coeff_we     = 1'b0;
    logic [1:0]        coeff_addr   = '0;
    logic signed [7:0] coeff_data   = '0;
    logic              coeff_commit = 1'b0;

    logic a_valid, a_ovf, b_valid, b_ovf, c_valid, c_ovf;
    logic [0:0] a_ch, b_ch, c_ch;
    logic signed [15:0] a_data, b_data, c_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_pipe u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .data_in(data_in),
        .flush(flush), .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
        .coeff_commit(coeff_commit), .out_valid(a_valid), .out_ch(a_ch), .data_out(a_data), .ovf(a_ovf)
    );

    fir_pipe #(.NUM_CH(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .data_in(data_in),
        .flush(flush), .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
        .coeff_commit(coeff_commit), .out_valid(b_valid), .out_ch(b_ch), .data_out(b_data), .ovf(b_ovf)
    );

    fir_pipe #(.OUT_SHIFT(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .data_in(data_in),
        .flush(flush), .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
        .coeff_commit(coeff_commit), .out_valid(c_valid), .out_ch(c_ch), .data_out(c_data), .ovf(c_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int v, input int f, input int d, input int fl, input int cm);
        in_valid     = 1'(v);
        in_first     = 1'(f);
        data_in      = 16'(d);
        flush        = 1'(fl);
        coeff_commit = 1'(cm);
        step();
    endtask

    task automatic load_coef(input int c0, input int c1, input int c2, input int c3);
        int cs [4];
        cs = '{c0, c1, c2, c3};
        for (int i = 0; i < 4; i++) begin
            coeff_we   = 1'b1;
            coeff_addr = 2'(i);
            coeff_data = 8'(cs[i]);
            step();
        end
        coeff_we     = 1'b0;
        coeff_commit = 1'b1;
        step();
        coeff_commit = 1'b0;
    endtask

    task automatic clear_lines();
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", a_valid); end
        checks++; if (a_data !== 16'sd0) begin errors++; $display("FAIL reset_data got %0d want 0", a_data); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", a_ovf); end
        checks++; if (b_ch !== 1'b0) begin errors++; $display("FAIL reset_ch got %0d want 0", b_ch); end
        checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_c got %0b want 0", c_valid); end
        rst_n = 1'b1;
        drive(1, 0, 5, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid got %0b want 1", a_valid); end
        checks++; if (a_data !== 16'sd0) begin errors++; $display("FAIL reset_coef_zero got %0d want 0", a_data); end
        step();
    endtask

    task automatic test_impulse();
        int iv [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        int id [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
        int ev [8] = '{0, 0, 1, 1, 1, 1, 1, 0};
        int ed [8] = '{0, 0, -2, -1, 3, 4, 0, 0};
        load_coef(-2, -1, 3, 4);
        clear_lines();
        for (int i = 0; i < 8; i++) begin
            drive(iv[i], 0, id[i], 0, 0);
            checks++;
            if (a_valid !== 1'(ev[i])) begin errors++; $display("FAIL impulse_valid[%0d] got %0b want %0d", i, a_valid, ev[i]); end
            if (ev[i] != 0) begin
                checks++;
                if (a_data !== 16'(ed[i])) begin errors++; $display("FAIL impulse_data[%0d] got %0d want %0d", i, a_data, ed[i]); end
            end
        end
    endtask

    task automatic test_commit();
        int iv [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        int id [10] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        int ic [10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int ed [10] = '{0, 0, -2, -1, 3, 4, 5, -1, 3, 4};
        clear_lines();
        coeff_we = 1'b1; coeff_addr = 2'd0; coeff_data = 8'sd5;
        step();
        coeff_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(iv[i], 0, id[i], 0, ic[i]);
            if (i >= 2) begin
                checks++;
                if (a_valid !== 1'b1 || a_data !== 16'(ed[i])) begin
                    errors++; $display("FAIL commit_seq[%0d] got v=%0b %0d want v=1 %0d", i, a_valid, a_data, ed[i]);
                end
            end
        end
        coeff_we = 1'b1; coeff_addr = 2'd0; coeff_data = 8'sd7; coeff_commit = 1'b1;
        step();
        coeff_we = 1'b0; coeff_commit = 1'b0;
        clear_lines();
        drive(1, 0, 1, 0, 0); drive(0, 0, 0, 0, 0); drive(0, 0, 0, 0, 0);
        checks++; if (a_data !== 16'sd5) begin errors++; $display("FAIL write_commit_same got %0d want 5", a_data); end
        drive(0, 0, 0, 0, 1);
        clear_lines();
        drive(1, 0, 1, 0, 0); drive(0, 0, 0, 0, 0); drive(0, 0, 0, 0, 0);
        checks++; if (a_data !== 16'sd7) begin errors++; $display("FAIL late_commit got %0d want 7", a_data); end
    endtask

    task automatic test_channels();
        int iv [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 0};
        int ifs[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        int id [14] = '{1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        int ev [14] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
        int ec [14] = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1};
        int ed [14] = '{0, 0, -2, -4, -1, -2, 3, 6, 4, 8, 0, -2, 0, 0};
        load_coef(-2, -1, 3, 4);
        clear_lines();
        for (int i = 0; i < 14; i++) begin
            drive(iv[i], ifs[i], id[i], 0, 0);
            checks++;
            if (b_valid !== 1'(ev[i])) begin errors++; $display("FAIL chan_valid[%0d] got %0b want %0d", i, b_valid, ev[i]); end
            if (ev[i] != 0) begin
                checks++;
                if (b_ch !== 1'(ec[i]) || b_data !== 16'(ed[i])) begin
                    errors++; $display("FAIL chan_out[%0d] got ch=%0d %0d want ch=%0d %0d", i, b_ch, b_data, ec[i], ed[i]);
                end
            end
        end
    endtask

    task automatic test_round();
        int iv [7] = '{1, 1, 1, 1, 1, 0, 0};
        int id [7] = '{6, -6, 2, 7, -7, 0, 0};
        int ed [7] = '{0, 0, 2, -1, 1, 2, -2};
        load_coef(1, 0, 0, 0);
        clear_lines();
        for (int i = 0; i < 7; i++) begin
            drive(iv[i], 0, id[i], 0, 0);
            if (i >= 2) begin
                checks++;
                if (c_valid !== 1'b1 || c_data !== 16'(ed[i])) begin
                    errors++; $display("FAIL round[%0d] got v=%0b %0d want v=1 %0d", i, c_valid, c_data, ed[i]);
                end
            end
        end
    endtask

    task automatic test_saturate();
        int iv [5] = '{1, 1, 1, 0, 0};
        int id [5] = '{32767, -32768, 100, 0, 0};
        int ed [5];
        int eo [5];
        ed = '{0, 0, SAT ? 32767 : 32641, -32768, 12700};
        eo = '{0, 0, SAT ? 1 : 0, SAT ? 1 : 0, 0};
        load_coef(127, 0, 0, 0);
        clear_lines();
        for (int i = 0; i < 5; i++) begin
            drive(iv[i], 0, id[i], 0, 0);
            if (i >= 2) begin
                checks++;
                if (a_data !== 16'(ed[i]) || a_ovf !== 1'(eo[i])) begin
                    errors++; $display("FAIL saturate[%0d] got %0d ovf=%0b want %0d ovf=%0d", i, a_data, a_ovf, ed[i], eo[i]);
                end
            end
        end
    endtask

    task automatic test_flush();
        int iv [10] = '{1, 1, 0, 1, 1, 1, 1, 1, 0, 0};
        int ifl[10] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
        int id [10] = '{1, 0, 0, 0, 0, 1, 2, 0, 0, 0};
        int ev [10] = '{0, 0, 1, 1, 0, 1, 1, 1, 1, 1};
        int ed [10] = '{0, 0, -2, -1, 0, 0, 0, -2, -4, -2};
        load_coef(-2, -1, 3, 4);
        clear_lines();
        for (int i = 0; i < 10; i++) begin
            drive(iv[i], 0, id[i], ifl[i], 0);
            checks++;
            if (a_valid !== 1'(ev[i])) begin errors++; $display("FAIL flush_valid[%0d] got %0b want %0d", i, a_valid, ev[i]); end
            if (ev[i] != 0) begin
                checks++;
                if (a_data !== 16'(ed[i])) begin errors++; $display("FAIL flush_data[%0d] got %0d want %0d", i, a_data, ed[i]); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %0b want 1", a_valid); end
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %0b want 0", a_valid); end
        checks++; if (a_data !== 16'sd0) begin errors++; $display("FAIL mid_async_data got %0d want 0", a_data); end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (a_valid !== 1'b0) begin errors++; $display("FAIL mid_after_valid[%0d] got %0b want 0", i, a_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_commit();
        test_channels();
        test_round();
        test_saturate();
        test_flush();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
